hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MDU_TIMEOUT, default 64: max MDU_BUSY cycles before abort.
REQ-002 Parameter CNT_W, default 16: width of stall_cycles.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 MemRead_ex  in  1  EX-stage instruction is a load.
REQ-006 rdAddr_ex  in  4  EX-stage destination register.
REQ-007 rs1Addr_id, rs2Addr_id  in  4 each  ID-stage source registers.
REQ-008 rs1Used_id, rs2Used_id  in  1 each  ID instruction actually reads rs1/rs2.
REQ-009 BranchTaken_ex  in  1  EX resolved a taken branch/jump (redirect).
REQ-010 mdu_start_ex  in  1  EX-stage instruction is a multi-cycle mul/div.
REQ-011 mdu_done  in  1  MDU result valid, one-cycle pulse.
REQ-012 perf_clr  in  1  clears stall_cycles.
REQ-013 Stall_if  out  1  hold PC.
REQ-014 Stall_id  out  1  hold IF/ID register.
REQ-015 Stall_ex  out  1  hold ID/EX, insert bubble into EX/MEM.
REQ-016 Bubble_ex  out  1  load NOP into ID/EX.
REQ-017 Flush_id  out  1  kill IF/ID contents.
REQ-018 mdu_go  out  1  one-cycle MDU start pulse.
REQ-019 mdu_err  out  1  sticky MDU timeout flag.
REQ-020 stall_cycles  out  CNT_W  saturating count of cycles with Stall_if=1.

Function
REQ-021 States: RUN, MDU_BUSY; control outputs Mealy (state + current inputs, same cycle).
REQ-022 Load-use hit = MemRead_ex & rdAddr_ex!=0 & ((rs1Used_id & rs1Addr_id==rdAddr_ex) | (rs2Used_id & rs2Addr_id==rdAddr_ex)).
REQ-023 RUN priority per cycle: BranchTaken_ex > mdu_start_ex > load-use hit.
REQ-024 RUN, BranchTaken_ex=1: Flush_id=1, Bubble_ex=1, no stalls, mdu_go=0, stay RUN.
REQ-025 RUN, mdu_start_ex=1 (no branch): mdu_go=1 that cycle, Stall_if=Stall_id=Stall_ex=1, next state MDU_BUSY, watchdog cleared.
REQ-026 RUN, load-use hit only: Stall_if=Stall_id=1, Bubble_ex=1 for exactly that cycle; stay RUN.
REQ-027 MDU_BUSY, mdu_done=0: Stall_if=Stall_id=Stall_ex=1; watchdog increments.
REQ-028 MDU_BUSY, mdu_done=1: all stalls 0 that cycle; next state RUN.
REQ-029 MDU_BUSY, watchdog reaches MDU_TIMEOUT-1 without mdu_done: set mdu_err, stalls 0 that cycle, next state RUN.
REQ-030 MDU_BUSY ignores BranchTaken_ex, mdu_start_ex, load-use; mdu_go=0.
REQ-031 mdu_done in RUN ignored.
REQ-032 stall_cycles +1 each cycle Stall_if=1; holds at all-ones; perf_clr has priority over increment (cleared to 0).
REQ-033 mdu_err cleared only by reset.

Reset
REQ-034 rst_n=0 at edge: state RUN, watchdog 0, stall_cycles 0, mdu_err 0.
REQ-035 While rst_n=0 all control outputs forced 0, including mid-MDU_BUSY.

Configuration
REQ-036 Macro HAZARD_MDU_EN defined: MDU path per REQ-025..REQ-031.
REQ-037 Undefined: ports kept; mdu_start_ex/mdu_done ignored, MDU_BUSY unreachable, mdu_go=Stall_ex=mdu_err=0 constant.

Structure
REQ-038 Package hazard_pkg: state enum, REG_ADDR_W=4, MDU_TIMEOUT default.
REQ-039 One sub-module load_use_detect computes REQ-022 combinationally.

Verification
REQ-040 MemRead_ex=1, rdAddr_ex=5, rs2Addr_id=5, rs2Used_id=1 -> Stall_if=Stall_id=Bubble_ex=1 one cycle, stall_cycles=1.
REQ-041 Same with rdAddr_ex=0, or rs2Used_id=0 -> no stall, no bubble.
REQ-042 BranchTaken_ex=1 with load-use hit -> Flush_id=Bubble_ex=1, Stall_if=0.
REQ-043 mdu_start_ex=1, mdu_done on 4th cycle after -> mdu_go one pulse, stalls 1 for 4 cycles, 0 on done cycle, stall_cycles=4.
REQ-044 mdu_start_ex=1, no mdu_done, MDU_TIMEOUT=8 -> mdu_err=1 after 8 MDU_BUSY cycles, state RUN, mdu_err holds.
REQ-045 rst_n=0 during MDU_BUSY with stall_cycles=0xFFFF -> outputs 0, stall_cycles=0, state RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_ADDR_W          = 4;
  localparam int MDU_TIMEOUT_DEFAULT = 64;
  localparam int CNT_W_DEFAULT       = 16;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MDU_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: EX load whose destination feeds an ID source operand.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic                  MemRead_ex,
  input  logic [REG_ADDR_W-1:0] rdAddr_ex,
  input  logic [REG_ADDR_W-1:0] rs1Addr_id,
  input  logic [REG_ADDR_W-1:0] rs2Addr_id,
  input  logic                  rs1Used_id,
  input  logic                  rs2Used_id,
  output logic                  hit
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = rs1Used_id && (rs1Addr_id == rdAddr_ex);
  assign rs2_match = rs2Used_id && (rs2Addr_id == rdAddr_ex);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hit = MemRead_ex && (rdAddr_ex != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, optional multi-cycle MDU
// interlock with watchdog (enabled by HAZARD_MDU_EN), and a saturating stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead_ex,
  input  logic [REG_ADDR_W-1:0] rdAddr_ex,
  input  logic [REG_ADDR_W-1:0] rs1Addr_id,
  input  logic [REG_ADDR_W-1:0] rs2Addr_id,
  input  logic                  rs1Used_id,
  input  logic                  rs2Used_id,
  input  logic                  BranchTaken_ex,
  input  logic                  mdu_start_ex,
  input  logic                  mdu_done,
  input  logic                  perf_clr,
  output logic                  Stall_if,
  output logic                  Stall_id,
  output logic                  Stall_ex,
  output logic                  Bubble_ex,
  output logic                  Flush_id,
  output logic                  mdu_go,
  output logic                  mdu_err,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic load_use;

  load_use_detect u_load_use_detect (
    .MemRead_ex (MemRead_ex),
    .rdAddr_ex  (rdAddr_ex),
    .rs1Addr_id (rs1Addr_id),
    .rs2Addr_id (rs2Addr_id),
    .rs1Used_id (rs1Used_id),
    .rs2Used_id (rs2Used_id),
    .hit        (load_use)
  );

`ifdef HAZARD_MDU_EN
  localparam int WD_W = $clog2(MDU_TIMEOUT + 1);

  state_e          state_q;
  state_e          state_d;
  logic [WD_W-1:0] wd_q;
  logic            timeout;
  logic            err_q;

  assign timeout = (wd_q == WD_W'(MDU_TIMEOUT - 1));
  assign mdu_err = err_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    Stall_if  = 1'b0;
    Stall_id  = 1'b0;
    Stall_ex  = 1'b0;
    Bubble_ex = 1'b0;
    Flush_id  = 1'b0;
    mdu_go    = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_RUN: begin
        if (BranchTaken_ex) begin
          Flush_id  = 1'b1;
          Bubble_ex = 1'b1;
        end else if (mdu_start_ex) begin
          mdu_go   = 1'b1;
          Stall_if = 1'b1;
          Stall_id = 1'b1;
          Stall_ex = 1'b1;
          state_d  = ST_MDU_BUSY;
        end else if (load_use) begin
          Stall_if  = 1'b1;
          Stall_id  = 1'b1;
          Bubble_ex = 1'b1;
        end
      end
      ST_MDU_BUSY: begin
        // Release the pipeline on the done cycle or when the watchdog gives up.
        if (mdu_done || timeout) begin
          state_d = ST_RUN;
        end else begin
          Stall_if = 1'b1;
          Stall_id = 1'b1;
          Stall_ex = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst_n) begin
      Stall_if  = 1'b0;
      Stall_id  = 1'b0;
      Stall_ex  = 1'b0;
      Bubble_ex = 1'b0;
      Flush_id  = 1'b0;
      mdu_go    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUN) begin
        wd_q <= '0;
      end else if (!mdu_done && !timeout) begin
        wd_q <= wd_q + WD_W'(1);
      end
      if ((state_q == ST_MDU_BUSY) && !mdu_done && timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_mdu;

  assign unused_mdu = ^{mdu_start_ex, mdu_done, 32'(MDU_TIMEOUT)};
  assign Stall_ex   = 1'b0;
  assign mdu_go     = 1'b0;
  assign mdu_err    = 1'b0;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    Stall_if  = 1'b0;
    Stall_id  = 1'b0;
    Bubble_ex = 1'b0;
    Flush_id  = 1'b0;
    if (rst_n) begin
      if (BranchTaken_ex) begin
        Flush_id  = 1'b1;
        Bubble_ex = 1'b1;
      end else if (load_use) begin
        Stall_if  = 1'b1;
        Stall_id  = 1'b1;
        Bubble_ex = 1'b1;
      end
    end
  end
`endif

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (Stall_if && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expectations follow HAZARD_MDU_EN.
module tb_hazard_ctrl;

  localparam int TO = 8;
`ifdef HAZARD_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  // Control vector order: Stall_if Stall_id Stall_ex Bubble_ex Flush_id mdu_go
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LOAD  = 6'b110100;
  localparam logic [5:0] C_BR    = 6'b000110;
  localparam logic [5:0] C_START = 6'b111001;
  localparam logic [5:0] C_BUSY  = 6'b111000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead_ex, rs1Used_id, rs2Used_id, BranchTaken_ex;
  logic        mdu_start_ex, mdu_done, perf_clr;
  logic [3:0]  rdAddr_ex, rs1Addr_id, rs2Addr_id;
  logic        Stall_if, Stall_id, Stall_ex, Bubble_ex, Flush_id, mdu_go, mdu_err;
  logic [15:0] stall_cycles;
  logic [5:0]  ctl;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign ctl = {Stall_if, Stall_id, Stall_ex, Bubble_ex, Flush_id, mdu_go};

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
    .BranchTaken_ex(BranchTaken_ex), .mdu_start_ex(mdu_start_ex),
    .mdu_done(mdu_done), .perf_clr(perf_clr),
    .Stall_if(Stall_if), .Stall_id(Stall_id), .Stall_ex(Stall_ex),
    .Bubble_ex(Bubble_ex), .Flush_id(Flush_id), .mdu_go(mdu_go),
    .mdu_err(mdu_err), .stall_cycles(stall_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
    rs1Used_id = 0; rs2Used_id = 0; BranchTaken_ex = 0;
    mdu_start_ex = 0; mdu_done = 0; perf_clr = 0;
  endtask

  task automatic set_hit(input logic [3:0] rd);
    MemRead_ex = 1; rdAddr_ex = rd; rs2Addr_id = rd; rs2Used_id = 1;
  endtask

  task automatic test_reset();
    idle();
    set_hit(4'd5);
    rst_n = 0;
    tick(); tick();
    if (ctl !== C_NONE) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
    n_cmp++;
    if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
    n_cmp++;
    if (mdu_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", mdu_err); end
    n_cmp++;
    idle();
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_use();
    set_hit(4'd5);
    #1;
    if (ctl !== C_LOAD) begin n_bad++; $display("FAIL lu_rs2_ctl: got %b want %b", ctl, C_LOAD); end
    n_cmp++;
    tick();
    idle();
    #1;
    if (ctl !== C_NONE) begin n_bad++; $display("FAIL lu_release: got %b want %b", ctl, C_NONE); end
    n_cmp++;
    if (stall_cycles !== 16'd1) begin n_bad++; $display("FAIL lu_cnt1: got %0d want 1", stall_cycles); end
    n_cmp++;
    MemRead_ex = 1; rdAddr_ex = 9; rs1Addr_id = 9; rs1Used_id = 1; rs2Addr_id = 9; rs2Used_id = 0;
    #1;
    if (ctl !== C_LOAD) begin n_bad++; $display("FAIL lu_rs1_ctl: got %b want %b", ctl, C_LOAD); end
    n_cmp++;
    tick();
    idle();
    if (stall_cycles !== 16'd2) begin n_bad++; $display("FAIL lu_cnt2: got %0d want 2", stall_cycles); end
    n_cmp++;
  endtask

  task automatic test_no_hazard();
    for (int v = 0; v < 4; v++) begin
      idle();
      case (v)
        0: begin set_hit(4'd0); end
        1: begin set_hit(4'd5); rs2Used_id = 0; end
        2: begin set_hit(4'd5); MemRead_ex = 0; end
        default: begin set_hit(4'd5); rs2Addr_id = 6; rs1Addr_id = 5; rs1Used_id = 0; end
      endcase
      #1;
      if (ctl !== C_NONE) begin n_bad++; $display("FAIL no_hazard_%0d: got %b want %b", v, ctl, C_NONE); end
      n_cmp++;
      tick();
    end
    idle();
    if (stall_cycles !== 16'd2) begin n_bad++; $display("FAIL no_hazard_cnt: got %0d want 2", stall_cycles); end
    n_cmp++;
  endtask

  task automatic test_branch();
    set_hit(4'd7);
    BranchTaken_ex = 1;
    #1;
    if (ctl !== C_BR) begin n_bad++; $display("FAIL branch_ctl: got %b want %b", ctl, C_BR); end
    n_cmp++;
    tick();
    idle();
    if (stall_cycles !== 16'd2) begin n_bad++; $display("FAIL branch_cnt: got %0d want 2", stall_cycles); end
    n_cmp++;
  endtask

  task automatic test_perf_clr();
    set_hit(4'd3);
    perf_clr = 1;
    tick();
    idle();
    if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL perf_clr_prio: got %0d want 0", stall_cycles); end
    n_cmp++;
  endtask

  task automatic test_mdu();
    logic [5:0] exp;
    set_hit(4'd3);
    mdu_start_ex = 1;
    #1;
    exp = MDU ? C_START : C_LOAD;
    if (ctl !== exp) begin n_bad++; $display("FAIL mdu_start: got %b want %b", ctl, exp); end
    n_cmp++;
    tick();
    for (int k = 1; k <= 4; k++) begin
      idle();
      if (k == 2) begin set_hit(4'd4); BranchTaken_ex = 1; mdu_start_ex = 1; end
      if (k == 4) mdu_done = 1;
      #1;
      if (k == 4)      exp = C_NONE;
      else if (k == 2) exp = MDU ? C_BUSY : C_BR;
      else             exp = MDU ? C_BUSY : C_NONE;
      if (ctl !== exp) begin n_bad++; $display("FAIL mdu_busy_%0d: got %b want %b", k, ctl, exp); end
      n_cmp++;
      tick();
    end
    idle();
    if (stall_cycles !== (MDU ? 16'd4 : 16'd1)) begin
      n_bad++; $display("FAIL mdu_cnt: got %0d want %0d", stall_cycles, MDU ? 4 : 1);
    end
    n_cmp++;
    mdu_done = 1;
    #1;
    if (ctl !== C_NONE) begin n_bad++; $display("FAIL done_in_run: got %b want %b", ctl, C_NONE); end
    n_cmp++;
    tick();
    idle();
    mdu_start_ex = 1; BranchTaken_ex = 1;
    #1;
    if (ctl !== C_BR) begin n_bad++; $display("FAIL branch_over_mdu: got %b want %b", ctl, C_BR); end
    n_cmp++;
    tick();
    idle();
    #1;
    if (ctl !== C_NONE) begin n_bad++; $display("FAIL no_busy_after_branch: got %b want %b", ctl, C_NONE); end
    n_cmp++;
    tick();
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    idle();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    mdu_start_ex = 1;
    #1;
    exp = MDU ? C_START : C_NONE;
    if (ctl !== exp) begin n_bad++; $display("FAIL to_start: got %b want %b", ctl, exp); end
    n_cmp++;
    tick();
    mdu_start_ex = 0;
    for (int k = 1; k <= TO; k++) begin
      #1;
      exp = (MDU && k < TO) ? C_BUSY : C_NONE;
      if (ctl !== exp) begin n_bad++; $display("FAIL to_busy_%0d: got %b want %b", k, ctl, exp); end
      n_cmp++;
      if (mdu_err !== 1'b0) begin n_bad++; $display("FAIL to_early_err_%0d: got %b want 0", k, mdu_err); end
      n_cmp++;
      tick();
    end
    if (mdu_err !== MDU) begin n_bad++; $display("FAIL to_err_set: got %b want %b", mdu_err, MDU); end
    n_cmp++;
    set_hit(4'd2);
    #1;
    if (ctl !== C_LOAD) begin n_bad++; $display("FAIL to_back_in_run: got %b want %b", ctl, C_LOAD); end
    n_cmp++;
    tick();
    idle();
    repeat (3) tick();
    if (mdu_err !== MDU) begin n_bad++; $display("FAIL to_err_sticky: got %b want %b", mdu_err, MDU); end
    n_cmp++;
    if (stall_cycles !== (MDU ? 16'd9 : 16'd1)) begin
      n_bad++; $display("FAIL to_cnt: got %0d want %0d", stall_cycles, MDU ? 9 : 1);
    end
    n_cmp++;
  endtask

  task automatic test_saturate_reset();
    logic [5:0] exp;
    idle();
    perf_clr = 1;
    tick();
    perf_clr = 0;
    set_hit(4'd11);
    repeat (65540) tick();
    idle();
    if (stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt: got %h want ffff", stall_cycles); end
    n_cmp++;
    mdu_start_ex = 1;
    tick();
    mdu_start_ex = 0;
    #1;
    exp = MDU ? C_BUSY : C_NONE;
    if (ctl !== exp) begin n_bad++; $display("FAIL sat_busy: got %b want %b", ctl, exp); end
    n_cmp++;
    if (stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", stall_cycles); end
    n_cmp++;
    tick();
    rst_n = 0;
    #1;
    if (ctl !== C_NONE) begin n_bad++; $display("FAIL rst_force_ctl: got %b want %b", ctl, C_NONE); end
    n_cmp++;
    tick();
    if (stall_cycles !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %h want 0", stall_cycles); end
    n_cmp++;
    if (mdu_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", mdu_err); end
    n_cmp++;
    rst_n = 1;
    #1;
    if (ctl !== C_NONE) begin n_bad++; $display("FAIL rst_state_run: got %b want %b", ctl, C_NONE); end
    n_cmp++;
    tick();
    set_hit(4'd1);
    #1;
    if (ctl !== C_LOAD) begin n_bad++; $display("FAIL rst_run_hit: got %b want %b", ctl, C_LOAD); end
    n_cmp++;
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_perf_clr();
    test_mdu();
    test_timeout();
    test_saturate_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
